quan_requant_pipe: RTL

- Parametrised successor to the post-accumulator ReLU/scale/clamp stage.
- Takes one beat of CH×LANES biased accumulator values and requantises each to OUT_W bits: per-channel arithmetic shift with optional round-half-up, per-channel zero point, then ReLU (unsigned) or signed saturation.
- Sits between the bias-add stage and the output write-back buffer.
- Adds a valid/ready backpressure pipeline, idle-gated configuration registers and a saturation statistics counter.

---
 rtl/quan_pkg.sv | 31 +++
 rtl/quan_lane_requant.sv | 78 +++++++
 rtl/quan_requant_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/quan_pkg.sv
// Shared definitions for the requantisation pipeline: mode encoding,
// element indexing and clamp bounds.
package quan_pkg;

  localparam logic MODE_RELU   = 1'b1;
  localparam logic MODE_SIGNED = 1'b0;

  // Flat element index of lane l in channel c.
  function automatic int unsigned elem_idx(input int unsigned c,
                                           input int unsigned lanes,
                                           input int unsigned l);
    return c * lanes + l;
  endfunction

  // Largest representable output value for the given mode.
  function automatic longint clamp_hi(input logic relu, input int unsigned out_w);
    if (relu == MODE_RELU)
      return (longint'(1) << out_w) - longint'(1);
    else
      return (longint'(1) << (out_w - 1)) - longint'(1);
  endfunction

  // Smallest representable output value for the given mode.
  function automatic longint clamp_lo(input logic relu, input int unsigned out_w);
    if (relu == MODE_RELU)
      return longint'(0);
    else
      return -(longint'(1) << (out_w - 1));
  endfunction

endpackage

// File: rtl/quan_lane_requant.sv
// One element's three-stage requantisation datapath:
// S1 rounding add, S2 arithmetic shift plus zero point, S3 clamp.
module quan_lane_requant
  import quan_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SH_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  input  logic               in_valid,
  input  logic               s1_valid,
  input  logic               s2_valid,
  input  logic               relu,
  input  logic               rnd,
  input  logic [SH_W-1:0]    sh,
  input  logic [OUT_W-1:0]   zp,
  input  logic [IN_W-1:0]    x,
  output logic [OUT_W-1:0]   result,
  output logic               sat
);

  localparam int unsigned TW = IN_W + 1;
  localparam int unsigned YW = IN_W + 2;

  logic signed [TW-1:0]  rnd_add;
  logic signed [TW-1:0]  t_d;
  logic signed [TW-1:0]  t_q;
  logic signed [YW-1:0]  zp_ext;
  logic signed [YW-1:0]  y_d;
  logic signed [YW-1:0]  y_q;
  logic        [OUT_W-1:0] r_d;
  longint                y_l;

  // S1: sign-extend one bit and add half an LSB of the shifted result when rounding.
  always_comb begin
    rnd_add = '0;
    if (rnd && sh != '0)
      rnd_add = TW'(1) << (sh - SH_W'(1));
    t_d = $signed({x[IN_W-1], x}) + rnd_add;
  end

  // S2: arithmetic shift, then zero point (sign-extended only in signed mode).
  always_comb begin
    zp_ext = {{(YW-OUT_W){zp[OUT_W-1] & (relu == MODE_SIGNED)}}, zp};
    y_d    = YW'(t_q >>> sh) + zp_ext;
  end

  // S3: clamp to the mode's range; ReLU zeroing of negatives is not saturation.
  always_comb begin
    y_l = longint'(y_q);
    r_d = y_q[OUT_W-1:0];
    sat = 1'b0;
    if (y_l > clamp_hi(relu, OUT_W)) begin
      r_d = OUT_W'(clamp_hi(relu, OUT_W));
      sat = 1'b1;
    end else if (y_l < clamp_lo(relu, OUT_W)) begin
      r_d = OUT_W'(clamp_lo(relu, OUT_W));
      sat = (relu == MODE_SIGNED);
    end
  end

  // Stage registers load only on advance and only for valid data; bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q    <= '0;
      y_q    <= '0;
      result <= '0;
    end else if (adv) begin
      if (in_valid) t_q    <= t_d;
      if (s1_valid) y_q    <= y_d;
      if (s2_valid) result <= r_d;
    end
  end

endmodule

// File: rtl/quan_requant_pipe.sv
// Post-accumulator requantisation: CH*LANES lanes, 3-stage valid/ready
// pipeline, idle-gated configuration and saturation statistics.
module quan_requant_pipe
  import quan_pkg::*;
#(
  parameter int unsigned LANES = 32,
  parameter int unsigned CH    = 2,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SH_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic                        cfg_relu,
  input  logic                        cfg_round,
  input  logic [CH*SH_W-1:0]          cfg_shift,
  input  logic [CH*OUT_W-1:0]         cfg_zp,
  output logic                        cfg_err,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CH*LANES*IN_W-1:0]    in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CH*LANES*OUT_W-1:0]   out_data,
  output logic                        busy,
  output logic [CNT_W-1:0]            sat_cnt,
  input  logic                        sat_clr
);

  logic                    s1_valid;
  logic                    s2_valid;
  logic                    adv;
  logic                    cfg_load;
  logic                    any_sat;
  logic                    relu_q;
  logic                    round_q;
  logic [CH*SH_W-1:0]      shift_q;
  logic [CH*OUT_W-1:0]     zp_q;
  logic                    relu_e;
  logic                    round_e;
  logic [CH*SH_W-1:0]      shift_e;
  logic [CH*OUT_W-1:0]     zp_e;
  logic [CH*LANES-1:0]     lane_sat;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy     = s1_valid | s2_valid | out_valid;
  assign cfg_load = cfg_we && !busy;
  assign any_sat  = |lane_sat;

  // A write accepted while idle is forwarded to the lanes so a beat entering in the
  // same cycle already uses it; S2/S3 only load while busy, when registers are stable.
  always_comb begin
    relu_e  = cfg_load ? cfg_relu  : relu_q;
    round_e = cfg_load ? cfg_round : round_q;
    shift_e = cfg_load ? cfg_shift : shift_q;
    zp_e    = cfg_load ? cfg_zp    : zp_q;
  end

  // Stage valids shift together on advance; bubbles are carried, not collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  // Configuration loads only while idle; a write while busy is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      relu_q  <= MODE_RELU;
      round_q <= 1'b0;
      shift_q <= '0;
      zp_q    <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_load) begin
        relu_q  <= cfg_relu;
        round_q <= cfg_round;
        shift_q <= cfg_shift;
        zp_q    <= cfg_zp;
      end
      if (cfg_we && busy)
        cfg_err <= 1'b1;
    end
  end

  // Count beats with any saturated lane as they load into S3; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || sat_clr)
      sat_cnt <= '0;
    else if (adv && s2_valid && any_sat && sat_cnt != '1)
      sat_cnt <= sat_cnt + 1'b1;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int unsigned E = elem_idx(c, LANES, l);
      quan_lane_requant #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SH_W  (SH_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .adv      (adv),
        .in_valid (in_valid),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid),
        .relu     (relu_e),
        .rnd      (round_e),
        .sh       (shift_e[c*SH_W +: SH_W]),
        .zp       (zp_e[c*OUT_W +: OUT_W]),
        .x        (in_data[E*IN_W +: IN_W]),
        .result   (out_data[E*OUT_W +: OUT_W]),
        .sat      (lane_sat[E])
      );
    end
  end

endmodule
